// File: rtl/dispense_pkg.sv
// Shared types and default constants for the dispense sequencer.
// Optional feature macro: DISPENSE_PAUSE_EN (adds a pause input to the top).
package dispense_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned N_CH_DEFAULT     = 3;
    localparam int unsigned CNT_W_DEFAULT    = 5;
    localparam int unsigned TICK_DIV_DEFAULT = 20000000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick prescaler: one-cycle tick every TICK_DIV clocks.
// clear forces the count to 0; hold freezes it and suppresses the tick.
module tick_prescaler
    import dispense_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count;

    // Tick fires on the last count of each period unless cleared or held
    always_comb begin
        tick = !clear && !hold && (count == LAST);
    end

    // Prescaler count: clear wins, hold freezes, otherwise count and wrap
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (!hold) begin
            if (count == LAST) count <= '0;
            else               count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dispense_sequencer.sv
// Multi-channel motor dispense sequencer (sequential or parallel runs).
// Optional feature macro: DISPENSE_PAUSE_EN adds a pause input that freezes a run.
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int unsigned N_CH     = N_CH_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    localparam int unsigned AW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode,
    input  logic [N_CH*CNT_W-1:0] cycles,
`ifdef DISPENSE_PAUSE_EN
    input  logic                  pause,
`endif
    output logic [N_CH-1:0]       motors,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         active_ch,
    output logic [CNT_W-1:0]      remaining
);

    state_t                       state, state_nxt;
    logic                         start_q;
    logic                         mode_q, mode_nxt;
    logic [N_CH-1:0][CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_CH-1:0]              cnt_nz, cyc_nz;
    logic [AW-1:0]                first_ch;
    logic                         start_rise;
    logic                         tick;
    logic                         paused;

`ifdef DISPENSE_PAUSE_EN
    // Pause only matters while a run is in progress
    always_comb begin
        paused = (state == RUN) && pause;
    end
`else
    // No pause feature in this build
    always_comb begin
        paused = 1'b0;
    end
`endif

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (state != RUN),
        .hold  (paused),
        .tick  (tick)
    );

    // Start edge detect, nonzero flags and lowest-index active channel
    always_comb begin
        start_rise = start && !start_q;
        first_ch   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_nz[i] = |cnt[i];
            cyc_nz[i] = |cycles[i*CNT_W +: CNT_W];
        end
        // Scan high to low so the lowest nonzero channel wins; empty channels are skipped
        for (int unsigned i = N_CH; i > 0; i--) begin
            if (cnt_nz[i-1]) first_ch = AW'(i - 1);
        end
    end

    // Next-state, counter load and decrement
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        case (state)
            IDLE: begin
                if (start_rise && !abort) begin
                    mode_nxt = mode;
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        cnt_nxt[i] = cycles[i*CNT_W +: CNT_W];
                    end
                    state_nxt = (|cyc_nz) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (tick) begin
                    // Sequential mode decrements only the active channel; the next
                    // nonzero channel becomes active on the same edge it reaches zero
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        if (cnt_nz[i] && (mode_q || (AW'(i) == first_ch))) begin
                            cnt_nxt[i] = cnt[i] - 1'b1;
                        end
                    end
                    if (cnt_nxt == '0) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from registered state and counters
    always_comb begin
        motors    = '0;
        active_ch = '0;
        remaining = '0;
        busy      = (state == RUN);
        done      = (state == DONE);
        if (state == RUN) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!paused && cnt_nz[i] && (mode_q || (AW'(i) == first_ch))) begin
                    motors[i] = 1'b1;
                end
            end
            if (!mode_q) begin
                active_ch = first_ch;
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (AW'(i) == first_ch) remaining = cnt[i];
                end
            end else begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (cnt[i] > remaining) remaining = cnt[i];
                end
            end
        end
    end

    // State, mode, counters and start-edge register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            mode_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= start;
            mode_q  <= mode_nxt;
            cnt     <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer (N_CH=3, CNT_W=5, TICK_DIV=4).
// Define DISPENSE_PAUSE_EN to also exercise the pause sequence.
module tb_dispense_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, abort, mode;
    logic [14:0] cycles;
`ifdef DISPENSE_PAUSE_EN
    logic        pause;
`endif
    logic [2:0]  motors;
    logic        busy, done;
    logic [1:0]  active_ch;
    logic [4:0]  remaining;

    dispense_sequencer #(
        .N_CH     (3),
        .CNT_W    (5),
        .TICK_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .cycles    (cycles),
`ifdef DISPENSE_PAUSE_EN
        .pause     (pause),
`endif
        .motors    (motors),
        .busy      (busy),
        .done      (done),
        .active_ch (active_ch),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, st, ab, md;
        logic [14:0] cyc;
        int          rep;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [14:0] SEQ_A = {5'd3, 5'd0, 5'd2};
    localparam logic [14:0] PAR_A = {5'd2, 5'd3, 5'd1};
    localparam logic [14:0] JUNK  = {5'd7, 5'd7, 5'd7};
    localparam logic [14:0] S333  = {5'd3, 5'd3, 5'd3};
    localparam logic [14:0] ZERO  = 15'd0;

    task automatic add(input logic rst, input logic st, input logic ab, input logic md,
                       input logic [14:0] cyc, input int rep,
                       input logic [2:0] m, input logic b, input logic d,
                       input logic [1:0] ac, input logic [4:0] rem);
        vec_t v;
        v.rst = rst; v.st = st; v.ab = ab; v.md = md;
        v.cyc = cyc; v.rep = rep;
        v.exp = {m, b, d, ac, rem};
        vecs.push_back(v);
    endtask

    function automatic logic [11:0] outs();
        return {motors, busy, done, active_ch, remaining};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int on_cnt;
    logic seen;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; cycles = '0;
`ifdef DISPENSE_PAUSE_EN
        pause = 1'b0;
`endif
        //  rst st ab md  cycles rep  motors  busy done act rem
        // reset state
        add(1, 0, 0, 0, ZERO,  2, 3'b000, 0, 0, 2'd0, 5'd0);
        // sequential {R=2,G=0,B=3}, start held high throughout
        add(0, 1, 0, 0, SEQ_A, 1, 3'b001, 1, 0, 2'd0, 5'd2);
        add(0, 1, 0, 0, SEQ_A, 3, 3'b001, 1, 0, 2'd0, 5'd2);
        add(0, 1, 0, 0, SEQ_A, 4, 3'b001, 1, 0, 2'd0, 5'd1);
        add(0, 1, 0, 0, SEQ_A, 4, 3'b100, 1, 0, 2'd2, 5'd3);
        add(0, 1, 0, 0, SEQ_A, 4, 3'b100, 1, 0, 2'd2, 5'd2);
        add(0, 1, 0, 0, SEQ_A, 4, 3'b100, 1, 0, 2'd2, 5'd1);
        add(0, 1, 0, 0, SEQ_A, 1, 3'b000, 0, 1, 2'd0, 5'd0);
        add(0, 1, 0, 0, SEQ_A, 3, 3'b000, 0, 0, 2'd0, 5'd0);
        // parallel {1,3,2}; mode/cycles changed mid-run must be ignored
        add(0, 0, 0, 1, PAR_A, 1, 3'b000, 0, 0, 2'd0, 5'd0);
        add(0, 1, 0, 1, PAR_A, 1, 3'b111, 1, 0, 2'd0, 5'd3);
        add(0, 1, 0, 0, JUNK,  3, 3'b111, 1, 0, 2'd0, 5'd3);
        add(0, 1, 0, 0, JUNK,  4, 3'b110, 1, 0, 2'd0, 5'd2);
        add(0, 1, 0, 0, JUNK,  4, 3'b010, 1, 0, 2'd0, 5'd1);
        add(0, 1, 0, 0, JUNK,  1, 3'b000, 0, 1, 2'd0, 5'd0);
        add(0, 0, 0, 0, JUNK,  1, 3'b000, 0, 0, 2'd0, 5'd0);
        // all counts zero: straight to DONE
        add(0, 1, 0, 0, ZERO,  1, 3'b000, 0, 1, 2'd0, 5'd0);
        add(0, 1, 0, 0, ZERO,  2, 3'b000, 0, 0, 2'd0, 5'd0);
        // sequential {3,3,3}, abort coinciding with the first tick
        add(0, 0, 0, 0, S333,  1, 3'b000, 0, 0, 2'd0, 5'd0);
        add(0, 1, 0, 0, S333,  1, 3'b001, 1, 0, 2'd0, 5'd3);
        add(0, 1, 0, 0, S333,  3, 3'b001, 1, 0, 2'd0, 5'd3);
        add(0, 1, 1, 0, S333,  1, 3'b000, 0, 0, 2'd0, 5'd0);
        add(0, 1, 0, 0, S333,  3, 3'b000, 0, 0, 2'd0, 5'd0);
        // start edge together with abort in IDLE stays IDLE
        add(0, 0, 0, 0, S333,  1, 3'b000, 0, 0, 2'd0, 5'd0);
        add(0, 1, 1, 0, S333,  1, 3'b000, 0, 0, 2'd0, 5'd0);
        add(0, 1, 0, 0, S333,  2, 3'b000, 0, 0, 2'd0, 5'd0);

        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].rep; r++) begin
                reset  = vecs[k].rst;
                start  = vecs[k].st;
                abort  = vecs[k].ab;
                mode   = vecs[k].md;
                cycles = vecs[k].cyc;
                step();
                check($sformatf("vec%0d.%0d", k, r), outs(), vecs[k].exp);
            end
        end

        // reset in the middle of a parallel {5,5,5} run, then a full rerun
        reset = 1'b0; abort = 1'b0; start = 1'b0; mode = 1'b1; cycles = {3{5'd5}};
        step();
        start = 1'b1;
        repeat (7) step();
        check("par_before_reset", outs(), {3'b111, 1'b1, 1'b0, 2'd0, 5'd4});
        reset = 1'b1; start = 1'b0;
        step();
        check("reset_mid_run", outs(), 12'd0);
        reset = 1'b0;
        step();
        check("idle_after_reset", outs(), 12'd0);
        start = 1'b1; on_cnt = 0; seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (motors == 3'b111) on_cnt++;
        end
        check("rerun_done_seen", {11'd0, seen}, 12'd1);
        check("rerun_on_cycles", 12'(on_cnt), 12'd20);
        start = 1'b0;
        step();

`ifdef DISPENSE_PAUSE_EN
        // sequential {2,0,0} with a 10-cycle pause after 3 motor cycles
        mode = 1'b0; cycles = {5'd0, 5'd0, 5'd2};
        step();
        start = 1'b1; on_cnt = 0; seen = 1'b0;
        repeat (3) begin
            step();
            if (motors != 3'b000) on_cnt++;
        end
        pause = 1'b1;
        repeat (10) begin
            step();
            check("pause_hold", {8'd0, motors, busy}, 12'd1);
        end
        pause = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (motors != 3'b000) on_cnt++;
        end
        check("pause_done_seen", {11'd0, seen}, 12'd1);
        check("pause_on_cycles", 12'(on_cnt), 12'd8);
        start = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dispense_sequencer.md
DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

Interface
REQ-001 Parameter N_CH, default 3: number of dispense channels (motors), range 1..8.
REQ-002 Parameter CNT_W, default 5: width of each per-channel cycle count.
REQ-003 Parameter TICK_DIV, default 20000000: clk cycles per dispense tick (400 ms at 50 MHz), minimum 2.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level input from the enter button; only its rising edge (registered internally) has effect.
REQ-007 abort  in  1  level; stops any run in progress.
REQ-008 mode  in  1  0 = sequential (one motor at a time), 1 = parallel (all motors together); sampled on the start edge.
REQ-009 cycles  in  N_CH*CNT_W  channel i count at bits [i*CNT_W +: CNT_W]; sampled on the start edge.
REQ-010 pause  in  1  freezes a run; port exists only when DISPENSE_PAUSE_EN is defined.
REQ-011 motors  out  N_CH  motor enables, bit i = channel i.
REQ-012 busy  out  1  high while in RUN.
REQ-013 done  out  1  one-cycle pulse on normal completion.
REQ-014 active_ch  out  max(1,clog2(N_CH))  current channel in sequential mode; 0 in parallel mode and IDLE.
REQ-015 remaining  out  CNT_W  ticks left on active_ch (sequential) or the maximum over channels (parallel); 0 in IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 IDLE to RUN: a start rising edge seen at cycle n gives busy=1 and the motors asserted at cycle n+1; the prescaler clears to 0 on entry.
REQ-018 A start edge with every channel count zero SHALL go IDLE to DONE, with done=1 at n+1 and no motor asserted.
REQ-019 A tick SHALL occur each time the prescaler reaches TICK_DIV-1; the prescaler then wraps to 0.
REQ-020 Sequential mode:
- The lowest-index channel with a nonzero count is loaded at start.
- Only its motor bit is high.
- Each tick decrements remaining.
- On the tick where remaining reaches 0, the next higher-index nonzero channel loads in the same clock edge, with no gap cycle.
- Zero-count channels are skipped combinationally.
- Channel i motor is high for exactly cycles_i*TICK_DIV clk cycles.
REQ-021 Parallel mode:
- Each channel has its own counter.
- motors[i] is high while counter i is nonzero.
- Every tick decrements all nonzero counters.
REQ-022 RUN to DONE SHALL occur on the tick that exhausts the last channel; motors drop at that same edge.
REQ-023 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-024 abort=1 in RUN SHALL give IDLE on the next edge with motors=0 and no done pulse; abort takes priority over a simultaneous tick.
REQ-025 A start edge during RUN or DONE SHALL be ignored, and a start level held across DONE SHALL NOT retrigger.
REQ-026 Simultaneous start edge and abort in IDLE SHALL leave the block in IDLE.
REQ-027 Input changes on cycles and mode during RUN SHALL have no effect.

Reset
REQ-028 reset SHALL take priority over all inputs, including in the middle of a run.
REQ-029 reset=1 SHALL produce IDLE, prescaler 0, counters 0, the start-edge register 0, and motors=0, busy=0, done=0, active_ch=0, remaining=0 on the next edge.

Configuration
REQ-030 Macro DISPENSE_PAUSE_EN defined:
- pause=1 in RUN freezes the prescaler and counters and forces motors=0 while busy stays 1.
- Releasing pause resumes from the frozen prescaler value.
- abort and reset still act while paused.
REQ-031 Macro DISPENSE_PAUSE_EN undefined: there is no pause port and no pause logic.

Structure
REQ-032 Package dispense_pkg SHALL hold the state enumeration (IDLE/RUN/DONE) and the default constants for N_CH, CNT_W and TICK_DIV.
REQ-033 The prescaler SHALL be a sub-module tick_prescaler with ports clk, reset, clear, hold, tick and parameter TICK_DIV.

Verification (N_CH=3, CNT_W=5, TICK_DIV=4)
REQ-034 Sequential, cycles={R=2,G=0,B=3}, start:
- motors=001 for 8 clk, then 100 for 12 clk, with no 000 gap.
- done pulses for 1 cycle and busy drops.
REQ-035 Parallel, cycles={1,3,2}, start:
- motors=111 for 4 clk, 110 for 4 clk, 010 for 4 clk.
- Then done.
REQ-036 All counts zero, start: done=1 one cycle after the edge; motors stay 000 and busy stays 0.
REQ-037 Sequential {3,3,3}:
- abort at clk 5: motors=000 and busy=0 next cycle, no done.
- start held high across the run: no retrigger.
REQ-038 Reset asserted mid-run (parallel {5,5,5}, clk 7): all outputs 0 next edge; a new start edge afterwards runs the full 20 clk.
REQ-039 With DISPENSE_PAUSE_EN, sequential {2,0,0}:
- pause held 10 clk starting at clk 3: motors=000 and busy=1 during the pause.
- Total motor-on time is still 8 clk.
